// File: rtl/vx_tcu_drl_acc_pipe.sv
// Three-stage handshaked significand accumulator for the TCU dot-product reduction lane.
// S0 extends/masks operands, S1 reduces them to sum/carry with 3:2 compressors, S2 does the final add.
module vx_tcu_drl_acc_pipe #(
  parameter int N     = 5,
  parameter int SIG_W = 25,
  parameter int TAG_W = 8,
  localparam int W    = SIG_W + $clog2(N) + 1
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 valid_in,
  output logic                 ready_in,
  input  logic [N*SIG_W-1:0]   sigs_in,
  input  logic                 fmt_sel,
  input  logic                 half_en,
  input  logic [TAG_W-1:0]     tag_in,
  output logic                 valid_out,
  input  logic                 ready_out,
  output logic [W-1:0]         sig_out,
  output logic [N-2:0]         signs_out,
  output logic [TAG_W-1:0]     tag_out,
  output logic [1:0]           in_flight
);

  // Handshake: a stage's contents move on only when the consumer is empty or moving on
  // in the same cycle; a transfer occurs at a rising edge with valid and ready both high.
  // flush wins over everything, including a simultaneous valid_out/ready_out handshake.

  logic                   s0_v_q, s0_v_d;
  logic [N-1:0][W-1:0]    s0_op_q, s0_op_d;
  logic [N-2:0]           s0_signs_q, s0_signs_d;
  logic [TAG_W-1:0]       s0_tag_q, s0_tag_d;

  logic                   s1_v_q, s1_v_d;
  logic [W-1:0]           s1_sum_q, s1_sum_d;
  logic [W-1:0]           s1_carry_q, s1_carry_d;
  logic [N-2:0]           s1_signs_q, s1_signs_d;
  logic [TAG_W-1:0]       s1_tag_q, s1_tag_d;

  logic                   s2_v_q, s2_v_d;
  logic [W-1:0]           s2_sum_q, s2_sum_d;
  logic [N-2:0]           s2_signs_q, s2_signs_d;
  logic [TAG_W-1:0]       s2_tag_q, s2_tag_d;

  logic [1:0]             in_flight_q, in_flight_d;

  logic                   s0_load, s1_load, s2_load;
  logic [SIG_W-1:0]       op_raw;
  logic [W-1:0]           op_ext;
  logic [W-1:0]           csa_s, csa_c, nxt_s, nxt_c;

  // Stage advance chain, resolved from the output back to the input.
  always_comb begin
    s2_load  = s1_v_q && (!s2_v_q || ready_out);
    s1_load  = s0_v_q && (!s1_v_q || s2_load);
    ready_in = !s0_v_q || s1_load || flush;
    s0_load  = valid_in && ready_in && !flush;

    s0_v_d = !flush && (s0_load || (s0_v_q && !s1_load));
    s1_v_d = !flush && (s1_load || (s1_v_q && !s2_load));
    s2_v_d = !flush && (s2_load || (s2_v_q && !ready_out));

    in_flight_d = {1'b0, s0_v_d} + {1'b0, s1_v_d} + {1'b0, s2_v_d};
  end

  // S0: extension, sparsity masking, raw sign capture.
  always_comb begin
    s0_op_d    = s0_op_q;
    s0_signs_d = s0_signs_q;
    s0_tag_d   = s0_tag_q;
    op_raw     = '0;
    op_ext     = '0;
    if (s0_load) begin
      for (int i = 0; i < N; i++) begin
        op_raw = sigs_in[i*SIG_W +: SIG_W];
        if (fmt_sel) op_ext = {{(W-SIG_W){1'b0}}, op_raw};
        else         op_ext = {{(W-SIG_W){op_raw[SIG_W-1]}}, op_raw};
        // C (last operand) and even-indexed products are never masked.
        if (!half_en && (i % 2 == 1) && (i < N-1)) op_ext = '0;
        s0_op_d[i] = op_ext;
      end
      for (int i = 0; i < N-1; i++) s0_signs_d[i] = sigs_in[i*SIG_W + SIG_W - 1];
      s0_tag_d = tag_in;
    end
  end

  // S1: carry-save reduction of N operands down to two vectors.
  always_comb begin
    csa_s = s0_op_q[0];
    csa_c = s0_op_q[1];
    nxt_s = '0;
    nxt_c = '0;
    for (int i = 2; i < N; i++) begin
      nxt_s = csa_s ^ csa_c ^ s0_op_q[i];
      nxt_c = ((csa_s & csa_c) | (csa_s & s0_op_q[i]) | (csa_c & s0_op_q[i])) << 1;
      csa_s = nxt_s;
      csa_c = nxt_c;
    end
    s1_sum_d   = s1_load ? csa_s      : s1_sum_q;
    s1_carry_d = s1_load ? csa_c      : s1_carry_q;
    s1_signs_d = s1_load ? s0_signs_q : s1_signs_q;
    s1_tag_d   = s1_load ? s0_tag_q   : s1_tag_q;
  end

  // S2: carry-propagate add; holds steady while the consumer stalls.
  always_comb begin
    s2_sum_d   = s2_load ? (s1_sum_q + s1_carry_q) : s2_sum_q;
    s2_signs_d = s2_load ? s1_signs_q : s2_signs_q;
    s2_tag_d   = s2_load ? s1_tag_q   : s2_tag_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s0_v_q      <= 1'b0;
      s0_op_q     <= '0;
      s0_signs_q  <= '0;
      s0_tag_q    <= '0;
      s1_v_q      <= 1'b0;
      s1_sum_q    <= '0;
      s1_carry_q  <= '0;
      s1_signs_q  <= '0;
      s1_tag_q    <= '0;
      s2_v_q      <= 1'b0;
      s2_sum_q    <= '0;
      s2_signs_q  <= '0;
      s2_tag_q    <= '0;
      in_flight_q <= '0;
    end else begin
      s0_v_q      <= s0_v_d;
      s0_op_q     <= s0_op_d;
      s0_signs_q  <= s0_signs_d;
      s0_tag_q    <= s0_tag_d;
      s1_v_q      <= s1_v_d;
      s1_sum_q    <= s1_sum_d;
      s1_carry_q  <= s1_carry_d;
      s1_signs_q  <= s1_signs_d;
      s1_tag_q    <= s1_tag_d;
      s2_v_q      <= s2_v_d;
      s2_sum_q    <= s2_sum_d;
      s2_signs_q  <= s2_signs_d;
      s2_tag_q    <= s2_tag_d;
      in_flight_q <= in_flight_d;
    end
  end

  assign valid_out = s2_v_q;
  assign sig_out   = s2_sum_q;
  assign signs_out = s2_signs_q;
  assign tag_out   = s2_tag_q;
  assign in_flight = in_flight_q;

endmodule

// File: tb/tb_vx_tcu_drl_acc_pipe.sv
// Bench for vx_tcu_drl_acc_pipe: directed literal cases, back-pressure, flush, reset,
// then randomized traffic checked every cycle against a queue-based reference model.
module tb_vx_tcu_drl_acc_pipe;

  localparam int N     = 5;
  localparam int SIG_W = 25;
  localparam int TAG_W = 8;
  localparam int W     = SIG_W + $clog2(N) + 1;

  logic               clk;
  logic               reset_n;
  logic               flush;
  logic               valid_in;
  logic               ready_in;
  logic [N*SIG_W-1:0] sigs_in;
  logic               fmt_sel;
  logic               half_en;
  logic [TAG_W-1:0]   tag_in;
  logic               valid_out;
  logic               ready_out;
  logic [W-1:0]       sig_out;
  logic [N-2:0]       signs_out;
  logic [TAG_W-1:0]   tag_out;
  logic [1:0]         in_flight;

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [W-1:0]     exp_q[$];
  logic [N-2:0]     exp_signs_q[$];
  logic [TAG_W-1:0] exp_tag_q[$];
  int               exp_rdy_q[$];

  vx_tcu_drl_acc_pipe #(.N(N), .SIG_W(SIG_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .valid_in(valid_in), .ready_in(ready_in), .sigs_in(sigs_in),
    .fmt_sel(fmt_sel), .half_en(half_en), .tag_in(tag_in),
    .valid_out(valid_out), .ready_out(ready_out), .sig_out(sig_out),
    .signs_out(signs_out), .tag_out(tag_out), .in_flight(in_flight)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc = cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_sum(input logic [N*SIG_W-1:0] ops,
                                             input logic fmt, input logic half);
    longint acc;
    longint v;
    acc = 0;
    for (int i = 0; i < N; i++) begin
      v = longint'(ops[i*SIG_W +: SIG_W]);
      if (!fmt && ops[i*SIG_W + SIG_W - 1]) v = v - (longint'(1) << SIG_W);
      if (!half && (i % 2 == 1) && (i < N-1)) v = 0;
      acc = acc + v;
    end
    return acc[W-1:0];
  endfunction

  function automatic logic [N-2:0] model_signs(input logic [N*SIG_W-1:0] ops);
    logic [N-2:0] s;
    for (int i = 0; i < N-1; i++) s[i] = ops[i*SIG_W + SIG_W - 1];
    return s;
  endfunction

  function automatic logic [N*SIG_W-1:0] pack5(input logic [SIG_W-1:0] o0, input logic [SIG_W-1:0] o1,
                                               input logic [SIG_W-1:0] o2, input logic [SIG_W-1:0] o3,
                                               input logic [SIG_W-1:0] o4);
    return {o4, o3, o2, o1, o0};
  endfunction

  function automatic logic [SIG_W-1:0] rand_op();
    logic [SIG_W-1:0] v;
    case ($urandom_range(0, 5))
      0:       v = '0;
      1:       v = '1;
      2:       v = {1'b1, {(SIG_W-1){1'b0}}};
      3:       v = {1'b0, {(SIG_W-1){1'b1}}};
      default: v = SIG_W'($urandom);
    endcase
    return v;
  endfunction

  function automatic logic [N*SIG_W-1:0] rand_ops();
    logic [N*SIG_W-1:0] r;
    for (int i = 0; i < N; i++) r[i*SIG_W +: SIG_W] = rand_op();
    return r;
  endfunction

  // ---------------- scoreboard / reference model ----------------
  // Expected item count equals the number of accepted-but-undelivered items; the head
  // becomes visible no earlier than the third edge counting its acceptance edge.
  always @(negedge clk) begin
    logic head_ok;
    logic m_ready;
    if (!reset_n) begin
      exp_q.delete(); exp_signs_q.delete(); exp_tag_q.delete(); exp_rdy_q.delete();
    end else begin
      head_ok = (exp_q.size() > 0) && (cyc >= exp_rdy_q[0]);
      chk("sb_valid_out", valid_out, head_ok);
      if (head_ok) begin
        chk("sb_sig_out", sig_out, exp_q[0]);
        chk("sb_signs_out", signs_out, exp_signs_q[0]);
        chk("sb_tag_out", tag_out, exp_tag_q[0]);
      end
      chk("sb_in_flight", in_flight, exp_q.size());
      m_ready = (exp_q.size() < 3) || ready_out || flush;
      chk("sb_ready_in", ready_in, m_ready);
      if (flush) begin
        exp_q.delete(); exp_signs_q.delete(); exp_tag_q.delete(); exp_rdy_q.delete();
      end else begin
        if (head_ok && ready_out) begin
          void'(exp_q.pop_front()); void'(exp_signs_q.pop_front());
          void'(exp_tag_q.pop_front()); void'(exp_rdy_q.pop_front());
        end
        if (valid_in && m_ready) begin
          exp_q.push_back(model_sum(sigs_in, fmt_sel, half_en));
          exp_signs_q.push_back(model_signs(sigs_in));
          exp_tag_q.push_back(tag_in);
          exp_rdy_q.push_back(cyc + 3);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_one(input string name, input logic [N*SIG_W-1:0] ops, input logic fmt,
                         input logic half, input logic [TAG_W-1:0] tag,
                         input logic [W-1:0] exp_sig, input logic [N-2:0] exp_signs);
    chk({name, "_model"}, model_sum(ops, fmt, half), exp_sig);
    @(posedge clk); #1;
    sigs_in = ops; fmt_sel = fmt; half_en = half; tag_in = tag;
    valid_in = 1'b1; ready_out = 1'b1; flush = 1'b0;
    @(negedge clk); chk({name, "_ready_in"}, ready_in, 1'b1);
    @(posedge clk); #1;
    valid_in = 1'b0;
    @(negedge clk); chk({name, "_lat1"}, valid_out, 1'b0);
    @(negedge clk); chk({name, "_lat2"}, valid_out, 1'b0);
    @(negedge clk);
    chk({name, "_valid"}, valid_out, 1'b1);
    chk({name, "_sig"}, sig_out, exp_sig);
    chk({name, "_signs"}, signs_out, exp_signs);
    chk({name, "_tag"}, tag_out, tag);
  endtask

  // Offers consecutive tags 0.. until 'want' are accepted or 'limit' cycles pass.
  // Entered and left at #1 after a rising edge.
  task automatic fill(input int want, input int limit, output int got);
    logic acc;
    got = 0;
    valid_in = 1'b1;
    for (int c = 0; c < limit && got < want; c++) begin
      tag_in  = TAG_W'(got);
      sigs_in = rand_ops();
      fmt_sel = 1'($urandom_range(0, 1));
      half_en = 1'($urandom_range(0, 1));
      @(negedge clk); acc = ready_in;
      @(posedge clk); #1;
      if (acc) got++;
    end
    valid_in = 1'b0;
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int got, seen, nxt, leak;
    logic acc;
    reset_n = 1'b0; flush = 1'b0; valid_in = 1'b0; ready_out = 1'b0;
    sigs_in = '0; fmt_sel = 1'b0; half_en = 1'b1; tag_in = '0;
    #1;
    chk("rst_valid_out", valid_out, 1'b0);
    chk("rst_sig_out", sig_out, '0);
    chk("rst_signs_out", signs_out, '0);
    chk("rst_tag_out", tag_out, '0);
    chk("rst_in_flight", in_flight, 2'd0);
    chk("rst_ready_in", ready_in, 1'b1);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;

    run_one("signed_sum", pack5(25'd1, 25'h1FFFFFF, 25'd2, 25'd3, 25'd4), 1'b0, 1'b1, 8'h5A,
            29'd9, 4'b0010);
    run_one("unsigned_max", pack5(25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF, 25'h1FFFFFF),
            1'b1, 1'b1, 8'h11, 29'h09FFFFFB, 4'b1111);
    run_one("signed_min", pack5(25'h1000000, 25'h1000000, 25'h1000000, 25'h1000000, 25'h1000000),
            1'b0, 1'b1, 8'h22, 29'h1B000000, 4'b1111);
    run_one("sparse_half0", pack5(25'd1, 25'd2, 25'd3, 25'd4, 25'd5), 1'b0, 1'b0, 8'h33,
            29'd9, 4'b0000);
    run_one("sparse_half1", pack5(25'd1, 25'd2, 25'd3, 25'd4, 25'd5), 1'b0, 1'b1, 8'h44,
            29'd15, 4'b0000);

    // Back-pressure: five offers against a stalled consumer.
    @(posedge clk); #1;
    ready_out = 1'b0;
    fill(5, 8, got);
    chk("bp_accepts", got, 3);
    @(negedge clk);
    chk("bp_ready_low", ready_in, 1'b0);
    chk("bp_in_flight", in_flight, 2'd3);
    chk("bp_valid_held", valid_out, 1'b1);
    chk("bp_tag_held", tag_out, 8'd0);
    @(posedge clk); #1;
    ready_out = 1'b1; valid_in = 1'b1; tag_in = 8'd3; sigs_in = rand_ops();
    #1 chk("bp_ready_rise", ready_in, 1'b1);
    nxt = 3; seen = 0;
    for (int c = 0; c < 16 && seen < 5; c++) begin
      @(negedge clk);
      if (valid_out && ready_out) begin
        chk("bp_order", tag_out, TAG_W'(seen));
        seen++;
      end
      acc = valid_in && ready_in;
      @(posedge clk); #1;
      if (acc) begin
        nxt++;
        if (nxt < 5) begin tag_in = TAG_W'(nxt); sigs_in = rand_ops(); end
        else valid_in = 1'b0;
      end
    end
    chk("bp_delivered", seen, 5);

    // Flush with three items in flight and an input offered during the flush.
    @(posedge clk); #1;
    ready_out = 1'b0;
    fill(3, 8, got);
    chk("fl_fill", got, 3);
    flush = 1'b1; valid_in = 1'b1; tag_in = 8'hEE; sigs_in = rand_ops();
    @(negedge clk); chk("fl_ready_in", ready_in, 1'b1);
    @(posedge clk); #1;
    flush = 1'b0; valid_in = 1'b0; ready_out = 1'b1;
    @(negedge clk);
    chk("fl_valid_out", valid_out, 1'b0);
    chk("fl_in_flight", in_flight, 2'd0);
    leak = 0;
    repeat (6) begin @(negedge clk); if (valid_out) leak++; end
    chk("fl_leak", leak, 0);

    // Asynchronous reset mid-stream.
    @(posedge clk); #1;
    ready_out = 1'b0;
    fill(3, 8, got);
    #2 reset_n = 1'b0;
    #1;
    chk("ar_valid_out", valid_out, 1'b0);
    chk("ar_sig_out", sig_out, '0);
    chk("ar_signs_out", signs_out, '0);
    chk("ar_tag_out", tag_out, '0);
    chk("ar_in_flight", in_flight, 2'd0);
    chk("ar_ready_in", ready_in, 1'b1);
    @(posedge clk); @(posedge clk); #1;
    reset_n = 1'b1; ready_out = 1'b1;
    leak = 0;
    repeat (5) begin @(negedge clk); if (valid_out) leak++; end
    chk("ar_leak", leak, 0);

    // Randomized traffic with varying back-pressure and occasional flush.
    for (int seg = 0; seg < 4; seg++) begin
      for (int c = 0; c < 120; c++) begin
        @(posedge clk); #1;
        valid_in  = ($urandom_range(0, 3) != 0);
        ready_out = ($urandom_range(0, 3) >= seg) || (seg == 0);
        flush     = ($urandom_range(0, 49) == 0);
        sigs_in   = rand_ops();
        fmt_sel   = 1'($urandom_range(0, 1));
        half_en   = 1'($urandom_range(0, 1));
        tag_in    = TAG_W'($urandom);
      end
    end

    @(posedge clk); #1;
    valid_in = 1'b0; flush = 1'b0; ready_out = 1'b1;
    repeat (8) @(posedge clk);
    @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
